// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver (and later the transmitter).
// The FIFO entry layout is fixed here so both directions agree on it.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } rx_state_t;

   typedef struct packed {
      logic       brk;
      logic       ferr;
      logic       perr;
      logic [7:0] data;
   } rx_entry_t;

   localparam int OVS        = 16;
   localparam int SAMPLE_LO  = 7;
   localparam int SAMPLE_MID = 8;
   localparam int SAMPLE_HI  = 9;
   localparam int ENTRY_W    = $bits(rx_entry_t);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO: the head entry is read combinationally from storage.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   output logic                   full,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count_reg != '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign level   = count_reg;
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   assign head    = valid ? mem[rd_ptr_reg] : '0;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ovs.sv
// UART receiver with 16x oversampling, 3-sample majority vote, parity/framing/break
// detection and a show-ahead FIFO of received characters.
module uart_rx_ovs
   import uart_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [DIV_W-1:0]            CFG_DIV,
   input  logic [1:0]                  CFG_DBITS,
   input  logic                        PARITY_EN,
   input  logic                        PARITY_ODD,
   input  logic                        RX,
   output logic [7:0]                  DATA,
   output logic                        PARITY_ERR,
   output logic                        FRAME_ERR,
   output logic                        BREAK,
   output logic                        VALID,
   input  logic                        READY,
   output logic [$clog2(FIFO_DEPTH):0] LEVEL,
   output logic                        OVERRUN,
   input  logic                        OVR_CLR
);

   rx_state_t              state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rx_prev_reg;
   logic [DIV_W-1:0]       presc_reg;
   logic [3:0]             tick_cnt_reg;
   logic                   s_lo_reg, s_mid_reg;
   logic [2:0]             bit_idx_reg;
   logic [7:0]             shift_reg;
   logic                   par_reg;
   logic [1:0]             dbits_reg;
   logic                   pen_reg, podd_reg;
   logic                   overrun_reg;

   logic       rx_s, counting, tick, at_lo, at_mid, at_hi, at_end;
   logic       vote, last_bit, push, fifo_full, drop;
   rx_entry_t  entry, head_entry;

   assign rx_s     = sync_reg[SYNC_STAGES-1];
   assign counting = (state_reg != uart_pkg::IDLE) && (state_reg != uart_pkg::BRK_WAIT);
   assign tick     = counting && (presc_reg >= CFG_DIV);
   assign at_lo    = tick && (tick_cnt_reg == 4'(SAMPLE_LO));
   assign at_mid   = tick && (tick_cnt_reg == 4'(SAMPLE_MID));
   assign at_hi    = tick && (tick_cnt_reg == 4'(SAMPLE_HI));
   assign at_end   = tick && (tick_cnt_reg == 4'(OVS - 1));
   assign vote     = maj3(s_lo_reg, s_mid_reg, rx_s);
   assign last_bit = (bit_idx_reg == (3'(dbits_reg) + 3'd4));

   // Entry fields are only meaningful in STOP at the mid-bit vote; push qualifies them.
   always_comb begin
      entry.data = shift_reg;
      entry.perr = pen_reg & ((^shift_reg ^ par_reg) != podd_reg);
      entry.ferr = ~vote;
      entry.brk  = ~vote & (shift_reg == 8'd0) & (~pen_reg | ~par_reg);
   end

   always_comb begin
      state_next = state_reg;
      push       = 1'b0;
      case (state_reg)
         uart_pkg::IDLE: begin
            if (rx_prev_reg && !rx_s) state_next = uart_pkg::START;
         end
         uart_pkg::START: begin
            if (at_hi && vote)  state_next = uart_pkg::IDLE;
            else if (at_end)    state_next = uart_pkg::DATA;
         end
         uart_pkg::DATA: begin
            if (at_end && last_bit) state_next = pen_reg ? uart_pkg::PARITY : uart_pkg::STOP;
         end
         uart_pkg::PARITY: begin
            if (at_end) state_next = uart_pkg::STOP;
         end
         uart_pkg::STOP: begin
            if (at_hi) begin
               push       = 1'b1;
               state_next = entry.brk ? uart_pkg::BRK_WAIT : uart_pkg::IDLE;
            end
         end
         uart_pkg::BRK_WAIT: begin
            if (rx_s) state_next = uart_pkg::IDLE;
         end
         default: state_next = uart_pkg::IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg   <= uart_pkg::IDLE;
         sync_reg    <= '1;
         rx_prev_reg <= 1'b1;
      end else begin
         state_reg   <= state_next;
         sync_reg    <= {sync_reg[SYNC_STAGES-2:0], RX};
         rx_prev_reg <= rx_s;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         presc_reg    <= '0;
         tick_cnt_reg <= '0;
         s_lo_reg     <= 1'b1;
         s_mid_reg    <= 1'b1;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         par_reg      <= 1'b0;
         dbits_reg    <= '0;
         pen_reg      <= 1'b0;
         podd_reg     <= 1'b0;
      end else begin
         if (!counting) begin
            presc_reg    <= '0;
            tick_cnt_reg <= '0;
         end else if (tick) begin
            presc_reg    <= '0;
            tick_cnt_reg <= tick_cnt_reg + 4'd1;
         end else begin
            presc_reg    <= presc_reg + DIV_W'(1);
         end
         if (at_lo)  s_lo_reg  <= rx_s;
         if (at_mid) s_mid_reg <= rx_s;
         // Frame format is frozen at the start edge so mid-frame config writes are harmless.
         if (state_reg == uart_pkg::IDLE && state_next == uart_pkg::START) begin
            dbits_reg   <= CFG_DBITS;
            pen_reg     <= PARITY_EN;
            podd_reg    <= PARITY_ODD;
            shift_reg   <= '0;
            par_reg     <= 1'b0;
            bit_idx_reg <= '0;
         end
         if (state_reg == uart_pkg::DATA) begin
            if (at_hi)               shift_reg[bit_idx_reg] <= vote;
            if (at_end && !last_bit) bit_idx_reg <= bit_idx_reg + 3'd1;
         end
         if (state_reg == uart_pkg::PARITY && at_hi) par_reg <= vote;
      end
   end

   assign drop = push & fifo_full & ~(READY & VALID);

   // A new overrun outranks a simultaneous clear so the event is never lost.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         overrun_reg <= 1'b0;
      end else if (drop) begin
         overrun_reg <= 1'b1;
      end else if (OVR_CLR) begin
         overrun_reg <= 1'b0;
      end
   end

   uart_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .push      (push),
      .push_data (entry),
      .full      (fifo_full),
      .pop       (READY),
      .head      (head_entry),
      .valid     (VALID),
      .level     (LEVEL)
   );

   assign DATA       = head_entry.data;
   assign PARITY_ERR = head_entry.perr;
   assign FRAME_ERR  = head_entry.ferr;
   assign BREAK      = head_entry.brk;
   assign OVERRUN    = overrun_reg;

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Second-generation UART receiver with 16x oversampling and 3-sample majority vote.
- Runtime baud divisor, 5–8 data bits, optional even/odd parity, stop-bit (framing) check and line-break detection.
- Received characters and their error flags go into a parametrised FIFO with a valid/ready read port.
- Sits between the board RX pin and the peripheral bus wrapper; the wrapper drains the FIFO.

Parameters:
DIV_W, 16, width of runtime baud divisor CFG_DIV
FIFO_DEPTH, 8, FIFO entries; power of two, >=2
SYNC_STAGES, 2, RX synchroniser flops, >=2

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
CFG_DIV  in  DIV_W  oversample tick every CFG_DIV+1 clocks (baud = f_CLK/(16*(CFG_DIV+1)))
CFG_DBITS  in  2  data bits: 0=5, 1=6, 2=7, 3=8
PARITY_EN  in  1  parity bit present
PARITY_ODD  in  1  1=odd, 0=even parity
RX  in  1  asynchronous serial input, idle high
DATA  out  8  head-entry character, right-aligned, unused MSBs zero
PARITY_ERR  out  1  head-entry parity mismatch
FRAME_ERR  out  1  head-entry stop bit sampled low
BREAK  out  1  head entry is a break condition
VALID  out  1  FIFO non-empty
READY  in  1  pop head when VALID&READY
LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
OVERRUN  out  1  sticky: frame dropped because FIFO full
OVR_CLR  in  1  clears OVERRUN

Behaviour:
- Reset values: FIFO empty, so VALID=0 and LEVEL=0. DATA/PARITY_ERR/FRAME_ERR/BREAK=0 and OVERRUN=0. FSM in IDLE. Synchroniser flops=1. Prescaler and tick counter=0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame with no push and empties the FIFO.
- Prescaler: counts 0..CFG_DIV and emits a 1-clock tick on reaching CFG_DIV, then wraps to 0.
  - CFG_DIV=0 means a tick every clock.
  - Prescaler and 4-bit tick counter are held at 0 in IDLE.
- Config latching: CFG_DBITS, PARITY_EN and PARITY_ODD are latched on IDLE->START. Changes mid-frame have no effect.
- Sampling: RX is sampled at ticks 7, 8 and 9 of each bit; bit value = majority of the three, resolved at tick 9. The bit ends at tick 15, and the tick counter wraps.
- FSM states:
  - IDLE: synchronised RX falling edge -> START.
  - START: vote=1 at tick 9 -> IDLE (false start, nothing pushed). At tick 15 -> DATA with bit index 0.
  - DATA: LSB first into shift register. Index reaches (CFG_DBITS+5)-1 at tick 15 -> PARITY if enabled, else STOP.
  - PARITY: vote stored; -> STOP at tick 15.
  - STOP: resolves at tick 9 (mid stop bit).
    - Parity error = PARITY_EN & (XOR(data bits, parity bit) != PARITY_ODD).
    - Frame error = stop vote 0.
    - Break = frame error & all data bits 0 & (parity bit 0 or parity disabled).
    - Push {BREAK, FRAME_ERR, PARITY_ERR, DATA}. Go to BRK_WAIT if break, else IDLE.
  - BRK_WAIT: stays until synchronised RX=1, then -> IDLE. A break therefore pushes exactly one entry.
- Push latency: the entry is visible on VALID/DATA on the clock after the STOP-state push cycle.
- FIFO:
  - Show-ahead: head entry is driven combinationally from storage.
  - Push when full without a simultaneous pop: frame dropped, OVERRUN<=1.
  - Push and pop in the same cycle when full: push accepted, LEVEL unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- OVERRUN: OVR_CLR clears it. If a set and a clear occur in the same cycle, set wins.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT).
  - rx_entry_t packed struct {brk, ferr, perr, data[7:0]}.
  - Constants OVS=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
- Sub-module: uart_fifo #(WIDTH, DEPTH), a synchronous show-ahead FIFO with async reset. The transmit side reuses it later.

Test Plan:
- CFG_DIV=3, 8N1, send 0xA5 -> one entry DATA=0xA5 with no flags. VALID rises 1 clk after the stop-bit mid-point (~9.6 bit times after the start edge).
- 7O1 (CFG_DBITS=2, PARITY_EN=1, PARITY_ODD=1), send 0x41 with parity bit 1 -> DATA=0x41 with no flags. Same frame with parity bit 0 -> PARITY_ERR=1.
- 1-clock-tick-wide low glitch on idle RX -> start vote=1, back to IDLE, LEVEL stays 0. Single-tick glitch inside a data bit -> majority rejects it and the data is correct.
- RX held low for 3 frame times (8N1) -> exactly one entry with DATA=0x00, FRAME_ERR=1, BREAK=1. No further entries until RX returns high; the next frame, 0x55, is received correctly.
- FIFO_DEPTH=4, READY=0, send 5 frames 0x01..0x05 -> LEVEL=4, OVERRUN=1, drain yields 0x01..0x04. OVR_CLR clears OVERRUN; OVR_CLR asserted in the same cycle as a new overrun leaves OVERRUN=1.
- Assert RESET during DATA bit 3 -> VALID=0 and no entry pushed. The next clean frame 0x3C is received correctly.
